// File: rtl/pe_prog_loader_pkg.sv
// Shared definitions for the PE program loader and the host-side frame generator:
// FSM state encoding, broadcast PE id and default frame-field widths.
package pe_prog_loader_pkg;

  localparam int DEF_NUM_PE     = 4;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 3;
  localparam int DEF_IN_WIDTH   = 8;

  // ID beat with every bit set targets all PEs at once.
  localparam logic [DEF_IN_WIDTH-1:0] BROADCAST_ID = '1;

  typedef enum logic [2:0] {
    S_ID     = 3'd0,
    S_LEN    = 3'd1,
    S_DATA   = 3'd2,
    S_DRAIN  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/pe_prog_decode.sv
// Combinational ID-beat decode: all-ones -> every PE, valid index -> one-hot mask,
// anything else -> empty mask with bad set. Zero latency, no flow control.
module pe_prog_decode
  import pe_prog_loader_pkg::*;
#(
  parameter int NUM_PE   = DEF_NUM_PE,
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic [IN_WIDTH-1:0] id,
  output logic [NUM_PE-1:0]   mask,
  output logic                bad
);

  always_comb begin
    mask = '0;
    bad  = 1'b0;
    if (&id) begin
      mask = '1;
    end else if (id < IN_WIDTH'(NUM_PE)) begin
      for (int i = 0; i < NUM_PE; i++) begin
        mask[i] = (id == IN_WIDTH'(i));
      end
    end else begin
      bad = 1'b1;
    end
  end

endmodule

// File: rtl/pe_prog_loader.sv
// Decodes host frames (ID, LEN, LEN+1 data words) into registered PE instruction-memory writes,
// one cycle after each data beat; ready stays high except for the single commit cycle.
module pe_prog_loader
  import pe_prog_loader_pkg::*;
#(
  parameter int NUM_PE     = DEF_NUM_PE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IN_WIDTH   = DEF_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [IN_WIDTH-1:0]   i_data,
  output logic [NUM_PE-1:0]     o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_pe_hold,
  output logic                  o_done,
  output logic                  o_err
);

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  last_word;
  logic [NUM_PE-1:0]     dec_mask;
  logic                  dec_bad;
  logic [NUM_PE-1:0]     mask_q;
  logic                  bad_q;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  assign o_ready   = (state != S_COMMIT);
  assign accept    = i_valid & o_ready;
  assign last_word = (word_cnt == '0);

  pe_prog_decode #(
    .NUM_PE   (NUM_PE),
    .IN_WIDTH (IN_WIDTH)
  ) u_decode (
    .id   (i_data),
    .mask (dec_mask),
    .bad  (dec_bad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_ID;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_ID:     if (accept) state_next = S_LEN;
      S_LEN:    if (accept) state_next = bad_q ? S_DRAIN : S_DATA;
      S_DATA:   if (accept && last_word) state_next = S_COMMIT;
      S_DRAIN:  if (accept && last_word) state_next = S_COMMIT;
      S_COMMIT: state_next = S_ID;
      default:  state_next = S_ID;
    endcase
  end

  // o_done is registered from the next state so it is high exactly during S_COMMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q    <= '0;
      bad_q     <= 1'b0;
      word_cnt  <= '0;
      addr_cnt  <= '0;
      o_we      <= '0;
      o_addr    <= '0;
      o_wdata   <= '0;
      o_pe_hold <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_we   <= '0;
      o_done <= (state != S_COMMIT) && (state_next == S_COMMIT);
      case (state)
        S_ID: begin
          if (accept) begin
            mask_q    <= dec_mask;
            bad_q     <= dec_bad;
            o_err     <= 1'b0;
            o_pe_hold <= ~dec_bad;
          end
        end
        S_LEN: begin
          if (accept) begin
            word_cnt <= i_data[ADDR_WIDTH-1:0];
            addr_cnt <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            o_we     <= mask_q;
            o_addr   <= addr_cnt;
            o_wdata  <= i_data[DATA_WIDTH-1:0];
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            word_cnt <= word_cnt - ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (accept) begin
            word_cnt <= word_cnt - ADDR_WIDTH'(1);
            if (last_word) o_err <= bad_q;
          end
        end
        S_COMMIT: begin
          o_pe_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_prog_loader.sv
// Randomized and directed frames for pe_prog_loader, checked against a frame-level reference model.
module tb_pe_prog_loader;
  import pe_prog_loader_pkg::*;

  logic       clk;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic [3:0] o_we;
  logic [2:0] o_addr;
  logic [2:0] o_wdata;
  logic       o_pe_hold;
  logic       o_done;
  logic       o_err;

  int         n_tests;
  int         n_fail;
  logic       exp_err;
  logic [7:0] fdata [8];

  pe_prog_loader #(
    .NUM_PE(4), .ADDR_WIDTH(3), .DATA_WIDTH(3), .IN_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .o_we      (o_we),
    .o_addr    (o_addr),
    .o_wdata   (o_wdata),
    .o_pe_hold (o_pe_hold),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps
  task automatic run_frame(input logic [7:0] id, input logic [7:0] len_beat, input int mode);
    logic [7:0] beats[$];
    logic [3:0] mask;
    bit         bad;
    int         len, idx, acc_idx, cyc, k;
    bit         drive, acc, alt;

    len = int'(len_beat[2:0]);
    if (id == BROADCAST_ID) begin
      mask = 4'hF; bad = 1'b0;
    end else if (id < 8'd4) begin
      mask = 4'b0001 << id[1:0]; bad = 1'b0;
    end else begin
      mask = 4'h0; bad = 1'b1;
    end
    beats.push_back(id);
    beats.push_back(len_beat);
    for (int i = 0; i <= len; i++) beats.push_back(fdata[i]);

    idx = 0; cyc = 0; alt = 1'b0;
    @(negedge clk);
    chk("err_pre", o_err, exp_err);
    chk("hold_pre", o_pe_hold, 0);
    while (idx < beats.size() && cyc < 200) begin
      drive   = (mode == 0) ? 1'b1 : (mode == 1) ? alt : 1'($urandom_range(0, 1));
      alt     = !alt;
      i_valid = drive;
      i_data  = drive ? beats[idx] : 8'($urandom);
      if (drive) chk("ready", o_ready, 1);
      @(posedge clk);
      acc = drive; acc_idx = idx;
      if (drive) idx++;
      @(negedge clk);
      cyc++;
      if (acc && acc_idx >= 2 && !bad) begin
        k = acc_idx - 2;
        chk("we", o_we, mask);
        chk("addr", o_addr, k);
        chk("wdata", o_wdata, fdata[k][2:0]);
        chk("hold_wr", o_pe_hold, 1);
      end else begin
        chk("we_idle", o_we, 0);
      end
      if (acc && acc_idx == 0) begin
        chk("err_clr", o_err, 0);
        chk("hold_set", o_pe_hold, !bad);
        exp_err = 1'b0;
      end
      if (idx < beats.size()) chk("done_early", o_done, 0);
    end
    i_valid = 1'b0;
    if (idx < beats.size()) begin
      chk("timeout", idx, beats.size());
    end else begin
      chk("done", o_done, 1);
      chk("err_commit", o_err, bad);
      chk("ready_commit", o_ready, 0);
      chk("hold_commit", o_pe_hold, !bad);
      @(negedge clk);
      chk("done_fall", o_done, 0);
      chk("hold_fall", o_pe_hold, 0);
      chk("ready_back", o_ready, 1);
      chk("we_after", o_we, 0);
      chk("err_sticky", o_err, bad);
      exp_err = bad;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_err = 1'b0;
    rst = 1'b0; i_valid = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", o_we, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_hold", o_pe_hold, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", o_ready, 1);

    fdata[0] = 8'h05; fdata[1] = 8'h01; fdata[2] = 8'h03;
    run_frame(8'h02, 8'h02, 0);
    fdata[0] = 8'h02;
    run_frame(8'hFF, 8'h00, 0);
    fdata[0] = 8'h01; fdata[1] = 8'h02;
    run_frame(8'h07, 8'h01, 0);
    fdata[0] = 8'h06; fdata[1] = 8'h04;
    run_frame(8'h00, 8'h01, 2);
    fdata[0] = 8'h05; fdata[1] = 8'h01; fdata[2] = 8'h03;
    run_frame(8'h02, 8'h02, 1);

    // Abort a LEN=7 frame after its second data beat.
    @(negedge clk);
    i_valid = 1'b1; i_data = 8'h01;
    @(posedge clk); #1 i_data = 8'h07;
    @(posedge clk); #1 i_data = 8'h05;
    @(posedge clk); #1 i_data = 8'h06;
    @(posedge clk); #1 i_valid = 1'b0;
    chk("we_pre_rst", o_we, 4'b0010);
    chk("addr_pre_rst", o_addr, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_we", o_we, 0);
    chk("mid_rst_addr", o_addr, 0);
    chk("mid_rst_wdata", o_wdata, 0);
    chk("mid_rst_hold", o_pe_hold, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_err", o_err, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", o_ready, 1);
    for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
    run_frame(8'h01, 8'h07, 0);

    for (int i = 0; i < 8; i++) fdata[i] = 8'hF8 + 8'(i);
    run_frame(8'h03, 8'h07, 0);

    for (int f = 0; f < 24; f++) begin
      int         r;
      logic [7:0] id;
      r = $urandom_range(0, 5);
      if (r == 0)      id = BROADCAST_ID;
      else if (r < 5)  id = 8'(r - 1);
      else             id = 8'($urandom_range(4, 254));
      for (int i = 0; i < 8; i++) fdata[i] = 8'($urandom);
      run_frame(id, 8'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
